// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: button front end for the alarm clock core.
// Debounces three raw push-buttons, runs a digit-by-digit HH:MM edit state
// machine and issues stretched load strobes that the core's slow 1 s
// domain is guaranteed to sample.
module time_entry_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int LOAD_HOLD  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       edit_active,
    output logic [1:0] edit_digit,
    output logic       edit_target
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LOAD_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EDIT_H1 = 3'd1,
        EDIT_H0 = 3'd2,
        EDIT_M1 = 3'd3,
        EDIT_M0 = 3'd4,
        LOAD    = 3'd5
    } state_t;

    // Bit 0 = mode, bit 1 = next, bit 2 = inc
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_inc, btn_next, btn_mode};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          deb_reg;
            logic          deb_d_reg;
            logic [DW-1:0] cnt_reg;

            // Synchronise, then only accept a level after it has differed
            // from the debounced value for DEB_CYCLES cycles in a row.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // One-cycle event on the debounced rising edge only
            assign press[gi] = deb_reg & ~deb_d_reg;
        end
    endgenerate

    // Fixed priority: mode beats next beats inc
    logic ev_mode;
    logic ev_next;
    logic ev_inc;

    assign ev_mode = press[0];
    assign ev_next = press[1] & ~press[0];
    assign ev_inc  = press[2] & ~press[1] & ~press[0];

    state_t        state_reg;
    state_t        state_next;
    logic [LW-1:0] load_cnt_reg;

    logic [1:0] h1_next;
    logic [3:0] h0_next;
    logic [3:0] m1_next;
    logic [3:0] m0_next;
    logic       target_next;
    logic       ld_time_next;
    logic       ld_alarm_next;
    logic       edit_active_next;
    logic [1:0] edit_digit_next;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counts the cycles spent in LOAD so the strobe is exactly LOAD_HOLD wide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_reg <= '0;
        end else if (state_reg == LOAD) begin
            load_cnt_reg <= load_cnt_reg + 1'b1;
        end else begin
            load_cnt_reg <= '0;
        end
    end

    // Next-state logic; events arriving during LOAD are simply not looked at
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ev_mode || ev_next) state_next = EDIT_H1;
            end
            EDIT_H1: begin
                if (ev_mode)      state_next = IDLE;
                else if (ev_next) state_next = EDIT_H0;
            end
            EDIT_H0: begin
                if (ev_mode)      state_next = IDLE;
                else if (ev_next) state_next = EDIT_M1;
            end
            EDIT_M1: begin
                if (ev_mode)      state_next = IDLE;
                else if (ev_next) state_next = EDIT_M0;
            end
            EDIT_M0: begin
                if (ev_mode)      state_next = IDLE;
                else if (ev_next) state_next = LOAD;
            end
            LOAD: begin
                if (load_cnt_reg == LW'(LOAD_HOLD - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Staged digit and target updates; every reachable value stays a legal HH:MM
    always_comb begin
        h1_next     = H_in1;
        h0_next     = H_in0;
        m1_next     = M_in1;
        m0_next     = M_in0;
        target_next = edit_target;
        if (state_reg == IDLE) begin
            if (ev_mode)      target_next = 1'b0;
            else if (ev_next) target_next = 1'b1;
        end
        if (ev_inc) begin
            case (state_reg)
                EDIT_H1: begin
                    if (H_in1 == 2'd2) begin
                        h1_next = 2'd0;
                    end else begin
                        h1_next = H_in1 + 2'd1;
                        // Entering the 20s: pull H0 down so 24..29 never appear
                        if (h1_next == 2'd2 && H_in0 > 4'd3) h0_next = 4'd3;
                    end
                end
                EDIT_H0: begin
                    if ((H_in1 == 2'd2 && H_in0 >= 4'd3) || H_in0 >= 4'd9) h0_next = 4'd0;
                    else                                                    h0_next = H_in0 + 4'd1;
                end
                EDIT_M1: begin
                    if (M_in1 >= 4'd5) m1_next = 4'd0;
                    else               m1_next = M_in1 + 4'd1;
                end
                EDIT_M0: begin
                    if (M_in0 >= 4'd9) m0_next = 4'd0;
                    else               m0_next = M_in0 + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from the upcoming state so registered outputs track it
    always_comb begin
        ld_time_next     = (state_next == LOAD) && !target_next;
        ld_alarm_next    = (state_next == LOAD) &&  target_next;
        edit_active_next = 1'b0;
        edit_digit_next  = 2'd0;
        case (state_next)
            EDIT_H1: begin edit_active_next = 1'b1; edit_digit_next = 2'd0; end
            EDIT_H0: begin edit_active_next = 1'b1; edit_digit_next = 2'd1; end
            EDIT_M1: begin edit_active_next = 1'b1; edit_digit_next = 2'd2; end
            EDIT_M0: begin edit_active_next = 1'b1; edit_digit_next = 2'd3; end
            default: ;
        endcase
    end

    // Output registers; async reset drops a strobe in flight immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            H_in1       <= 2'd0;
            H_in0       <= 4'd0;
            M_in1       <= 4'd0;
            M_in0       <= 4'd0;
            LD_time     <= 1'b0;
            LD_alarm    <= 1'b0;
            edit_active <= 1'b0;
            edit_digit  <= 2'd0;
            edit_target <= 1'b0;
        end else begin
            H_in1       <= h1_next;
            H_in0       <= h0_next;
            M_in1       <= m1_next;
            M_in0       <= m0_next;
            LD_time     <= ld_time_next;
            LD_alarm    <= ld_alarm_next;
            edit_active <= edit_active_next;
            edit_digit  <= edit_digit_next;
            edit_target <= target_next;
        end
    end

endmodule

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
- Upstream stage of the alarm clock core; the user sets time and alarm with three push-buttons.
- Debounces the raw buttons and runs a digit-by-digit edit state machine over HH:MM.
- Drives the core's digit inputs H_in1/H_in0/M_in1/M_in0.
- Issues stretched LD_time/LD_alarm strobes, long enough for the core's divided 1 s clock domain to sample them.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles of a synchronised button before its debounced level changes.
- LOAD_HOLD, 12: cycles LD_time/LD_alarm stay high. Must exceed one core clk_1s period (10 clk).

Ports:
- clk  in  1  system clock, same clock as the core
- reset  in  1  asynchronous, active-low reset
- btn_mode  in  1  raw button, async: start time edit / abort edit
- btn_next  in  1  raw button, async: start alarm edit / advance digit
- btn_inc  in  1  raw button, async: increment current digit
- H_in1  out  2  staged hour tens, 0..2
- H_in0  out  4  staged hour units, BCD
- M_in1  out  4  staged minute tens, 0..5
- M_in0  out  4  staged minute units, 0..9
- LD_time  out  1  load-time strobe, LOAD_HOLD cycles wide
- LD_alarm  out  1  load-alarm strobe, LOAD_HOLD cycles wide
- edit_active  out  1  high in any EDIT_* state
- edit_digit  out  2  digit under edit: 0=H1, 1=H0, 2=M1, 3=M0
- edit_target  out  1  0 = time, 1 = alarm

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, synchronisers/debounce counters/debounced levels 0. Reset mid-LOAD drops the strobe immediately; no partial load is replayed.
- Button path, per button:
  - 2-flop synchroniser produces s.
  - Counter increments while s != deb and clears while s == deb.
  - After DEB_CYCLES consecutive mismatching cycles, deb <= s and the counter clears.
  - Press event = one-cycle pulse on the rising edge of deb; release generates nothing.
  - A held button yields exactly one event (no auto-repeat).
- Event priority in the same cycle: mode > next > inc; lower-priority events that cycle are dropped.
- States: IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, LOAD.
- IDLE:
  - mode event -> EDIT_H1, edit_target=0.
  - next event -> EDIT_H1, edit_target=1.
  - inc is ignored.
  - Staged digits keep their last values; they are not cleared on edit entry.
- EDIT_*:
  - inc increments the current digit with wrap:
    - H1: 0..2.
    - H0: 0..9 when H1<2, 0..3 when H1==2.
    - M1: 0..5.
    - M0: 0..9.
  - When H1 changes to 2 and H0>3, H0 is forced to 3 in the same cycle.
  - next moves H1->H0->M1->M0; next in EDIT_M0 -> LOAD.
  - mode aborts to IDLE: no strobe, staged digits retain their edited values.
- LOAD:
  - LD_time (target 0) or LD_alarm (target 1) is high for exactly LOAD_HOLD cycles, starting the cycle after entry.
  - Digits are frozen; all button events are ignored and discarded.
  - Then -> IDLE. The strobes are never high simultaneously.
- Outputs are registered. The staged value is always a legal 00:00..23:59.
- edit_digit reflects the current state; it is 0 outside EDIT_*.

Test Plan:
- Reset with buttons idle -> all outputs 0, state IDLE; glitch btn_inc for 3 cycles (DEB_CYCLES=4) -> no digit change.
- Time set: mode, inc x2, next, inc x5 (H0 wraps 0..3 so 5 -> 1), next, inc x4, next, inc x9, next -> staged 21:49, LD_time high exactly 12 cycles, LD_alarm stays 0, then IDLE.
- Clamp: stage 19, return to H1, inc -> H1=2 and H0=3 the same cycle; inc again -> H1=0, H0 stays 3.
- Alarm set with abort: next, inc on H1, then mode -> IDLE, H_in1=1, no strobe; next, then next x4 -> LD_alarm 12 cycles, target=1.
- Simultaneous mode+inc events in EDIT_H0 -> abort to IDLE, digit unchanged; button presses during LOAD ignored, strobe width unchanged.
- Async reset asserted mid-LOAD at strobe cycle 5 -> LD_time drops without clk edge, digits 0 after release.
